// File: rtl/morse_key_scheduler.sv
// rtl/morse_key_scheduler.sv - two-requester round-robin Morse symbol keyer
module morse_key_scheduler #(
    parameter int UNIT_TICKS = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic [7:0] sym_bits0,
    input  logic [7:0] sym_bits1,
    input  logic [3:0] sym_len0,
    input  logic [3:0] sym_len1,
    output logic [1:0] ack,
    output logic       gnt_id,
    output logic       busy,
    output logic       done,
    output logic       key_out
);
    typedef enum logic [1:0] {IDLE, MARK, SPACE, LGAP} state_t;

    localparam logic [9:0] ONE_UNIT   = 10'(UNIT_TICKS - 1);
    localparam logic [9:0] THREE_UNIT = 10'(3 * UNIT_TICKS - 1);

    state_t     state_q, state_d;
    logic [9:0] cnt_q, cnt_d;
    logic [7:0] bits_q, bits_d;
    logic [3:0] rem_q, rem_d;
    logic       prio_q, prio_d;
    logic       zpend_q, zpend_d;
    logic [1:0] ack_q, ack_d;
    logic       gnt_q, gnt_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       key_q, key_d;

    logic       winner;
    logic [7:0] sel_bits;
    logic [3:0] sel_len;
    logic [3:0] len_c;

    always_comb begin
        winner   = (req == 2'b11) ? prio_q : req[1];
        sel_bits = winner ? sym_bits1 : sym_bits0;
        sel_len  = winner ? sym_len1 : sym_len0;
        len_c    = (sel_len > 4'd8) ? 4'd8 : sel_len;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bits_d  = bits_q;
        rem_d   = rem_q;
        prio_d  = prio_q;
        gnt_d   = gnt_q;
        zpend_d = 1'b0;
        ack_d   = 2'b00;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                // A zero-length symbol parks here for its ack cycle; block re-grant until its done.
                if (zpend_q) begin
                    done_d = 1'b1;
                end else if (req != 2'b00) begin
                    ack_d  = winner ? 2'b10 : 2'b01;
                    gnt_d  = winner;
                    prio_d = ~winner;
                    bits_d = sel_bits;
                    if (len_c == 4'd0) begin
                        zpend_d = 1'b1;
                    end else begin
                        state_d = MARK;
                        rem_d   = len_c - 4'd1;
                        cnt_d   = sel_bits[0] ? THREE_UNIT : ONE_UNIT;
                    end
                end
            end
            MARK: begin
                if (cnt_q == 10'd0) begin
                    if (rem_q != 4'd0) begin
                        state_d = SPACE;
                        cnt_d   = ONE_UNIT;
                    end else begin
                        state_d = LGAP;
                        cnt_d   = THREE_UNIT;
                    end
                end else begin
                    cnt_d = cnt_q - 10'd1;
                end
            end
            SPACE: begin
                if (cnt_q == 10'd0) begin
                    state_d = MARK;
                    bits_d  = {1'b0, bits_q[7:1]};
                    rem_d   = rem_q - 4'd1;
                    cnt_d   = bits_q[1] ? THREE_UNIT : ONE_UNIT;
                end else begin
                    cnt_d = cnt_q - 10'd1;
                end
            end
            LGAP: begin
                if (cnt_q == 10'd0) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 10'd1;
                end
            end
            default: state_d = IDLE;
        endcase
        key_d  = (state_d == MARK);
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 10'd0;
            bits_q  <= 8'd0;
            rem_q   <= 4'd0;
            prio_q  <= 1'b0;
            zpend_q <= 1'b0;
            ack_q   <= 2'b00;
            gnt_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            key_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bits_q  <= bits_d;
            rem_q   <= rem_d;
            prio_q  <= prio_d;
            zpend_q <= zpend_d;
            ack_q   <= ack_d;
            gnt_q   <= gnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            key_q   <= key_d;
        end
    end

    assign ack     = ack_q;
    assign gnt_id  = gnt_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign key_out = key_q;
endmodule

// File: tb/tb_morse_key_scheduler.sv
// tb/tb_morse_key_scheduler.sv - directed self-checking bench for morse_key_scheduler
module tb_morse_key_scheduler;
    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] req;
    logic [7:0] sym_bits0, sym_bits1;
    logic [3:0] sym_len0, sym_len1;
    logic [1:0] ack;
    logic       gnt_id, busy, done, key_out;

    int checks = 0;
    int errors = 0;

    morse_key_scheduler #(.UNIT_TICKS(2)) dut (
        .clk(clk), .rst(rst), .req(req),
        .sym_bits0(sym_bits0), .sym_bits1(sym_bits1),
        .sym_len0(sym_len0), .sym_len1(sym_len1),
        .ack(ack), .gnt_id(gnt_id), .busy(busy), .done(done), .key_out(key_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] req;
        logic [7:0] bits0;
        logic [3:0] len0;
        logic [7:0] bits1;
        logic [3:0] len1;
        logic [1:0] exp_ack;
        logic       exp_gnt;
        int         exp_high;
        int         exp_dur;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_ack(output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (ack != 2'b00) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("ack_timeout", 0, 1);
    endtask

    task automatic wait_done(output int dur, output int high, output logic [63:0] pat);
        logic got;
        got  = 1'b0;
        dur  = 0;
        high = 0;
        pat  = '0;
        for (int i = 0; i < 300; i++) begin
            if (done) begin
                got = 1'b1;
                break;
            end
            dur++;
            high += int'(key_out);
            pat = {pat[62:0], key_out};
            @(negedge clk);
        end
        if (!got) check("done_timeout", 0, 1);
        else      check("ack_done_overlap", {30'd0, ack}, 0);
    endtask

    task automatic run_vec(input vec_t v, input string tag, output logic [63:0] pat);
        logic ok;
        int   dur, high;
        sym_bits0 = v.bits0; sym_len0 = v.len0;
        sym_bits1 = v.bits1; sym_len1 = v.len1;
        req = v.req;
        wait_ack(ok);
        pat = '0;
        if (ok) begin
            check({tag, "_ack"}, {30'd0, ack}, {30'd0, v.exp_ack});
            check({tag, "_gnt"}, {31'd0, gnt_id}, {31'd0, v.exp_gnt});
            check({tag, "_key_at_ack"}, {31'd0, key_out}, {31'd0, v.exp_high != 0});
            req = 2'b00;
            wait_done(dur, high, pat);
            check({tag, "_dur"}, dur, v.exp_dur);
            check({tag, "_high"}, high, v.exp_high);
            check({tag, "_busy_at_done"}, {31'd0, busy}, 0);
            check({tag, "_key_at_done"}, {31'd0, key_out}, 0);
        end
        req = 2'b00;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [63:0] pat;
        logic        ok;
        logic        saw_done;
        int          dur, high;

        // req, bits0, len0, bits1, len1, ack, gnt, key-high cycles, ack-to-done cycles
        vecs[0] = '{2'b01, 8'h00, 4'd3,  8'h00, 4'd0, 2'b01, 1'b0, 6,  16};
        vecs[1] = '{2'b10, 8'h00, 4'd0,  8'h07, 4'd3, 2'b10, 1'b1, 18, 28};
        vecs[2] = '{2'b01, 8'h55, 4'd0,  8'h00, 4'd0, 2'b01, 1'b0, 0,  1};
        vecs[3] = '{2'b01, 8'hFF, 4'd12, 8'h00, 4'd0, 2'b01, 1'b0, 48, 68};
        vecs[4] = '{2'b10, 8'h00, 4'd0,  8'h02, 4'd2, 2'b10, 1'b1, 8,  16};
        vecs[5] = '{2'b01, 8'h01, 4'd1,  8'h00, 4'd0, 2'b01, 1'b0, 6,  12};

        req = 2'b00; sym_bits0 = '0; sym_bits1 = '0; sym_len0 = '0; sym_len1 = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_key", {31'd0, key_out}, 0);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_done", {31'd0, done}, 0);
        check("rst_ack", {30'd0, ack}, 0);
        check("rst_gnt", {31'd0, gnt_id}, 0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i), pat);
            if (i == 0) check("s_waveform", {16'd0, pat[15:0]}, {16'd0, 16'b1100110011000000});
            if (i == 1) check("o_waveform", pat[27:0], 28'b1111110011111100111111000000);
        end

        // Both requesters held: grants alternate, each ack one cycle after the previous done.
        do_reset();
        sym_bits0 = 8'h00; sym_len0 = 4'd1;
        sym_bits1 = 8'h00; sym_len1 = 4'd1;
        req = 2'b11;
        wait_ack(ok);
        if (ok) begin
            for (int k = 0; k < 4; k++) begin
                check($sformatf("rr_ack%0d", k), {30'd0, ack}, (k % 2 == 1) ? 2'b10 : 2'b01);
                check($sformatf("rr_gnt%0d", k), {31'd0, gnt_id}, (k % 2 == 1) ? 1 : 0);
                wait_done(dur, high, pat);
                check($sformatf("rr_dur%0d", k), dur, 8);
                if (k == 3) req = 2'b00;
                @(negedge clk);
                if (k < 3) check($sformatf("rr_gap%0d", k), {31'd0, ack != 2'b00}, 1);
            end
        end
        req = 2'b00;
        repeat (2) @(negedge clk);

        // Reset during the second mark of "S" aborts without done.
        do_reset();
        sym_bits0 = 8'h00; sym_len0 = 4'd3;
        req = 2'b01;
        wait_ack(ok);
        req = 2'b00;
        repeat (4) @(negedge clk);
        check("abort_mark2_key", {31'd0, key_out}, 1);
        rst = 1'b1;
        @(negedge clk);
        check("abort_key", {31'd0, key_out}, 0);
        check("abort_busy", {31'd0, busy}, 0);
        check("abort_done", {31'd0, done}, 0);
        rst = 1'b0;
        saw_done = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        check("abort_no_done", {31'd0, saw_done}, 0);
        run_vec(vecs[0], "after_abort", pat);
        check("after_abort_waveform", {16'd0, pat[15:0]}, {16'd0, 16'b1100110011000000});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
